list_length_counter: RTL and testbench

Parametrised pointer-stream walker for the vector-norm datapath: consumes successive PC/pointer values of a linked list over a valid/ready handshake, compares each against a selectable terminator condition, and counts the nodes until the list ends. It replaces the single-shot PC-versus-zero comparator. It adds a start/busy/done control sequence, a discard of the initial PC beat, four terminate modes (including circular lists), and an optional runaway guard. The result feeds the Length register consumed by the norm sequencer.

---
 rtl/list_length_counter.sv | 205 ++++++++++++++++++++
 tb/tb_list_length_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_length_counter.sv
// ---------------------------------------------------------------------------
// list_length_counter
//
// Pointer-stream walker for the vector-norm datapath. After i_start it takes
// successive PC/pointer values over a valid/ready handshake. It discards the
// first beat, which carries the initial PC. It then counts list nodes until a
// beat meets the terminate condition latched at start. The count drives the
// Length register read by the norm sequencer.
//
// Optional feature macro: LIST_LEN_GUARD_EN
//   defined   : the walk stops with f_overrun=1 when a non-terminating beat
//               arrives while o_length == MAX_NODES.
//   undefined : no limit; o_length wraps modulo 2^LEN_WIDTH; f_overrun stays 0.
//
// Parameters
//   WORD_SIZE  pointer / PC width
//   LEN_WIDTH  width of o_length
//   MAX_NODES  runaway guard limit (guard build only), must be < 2^LEN_WIDTH
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any walk without o_done
//   i_start      begin a walk (sampled in IDLE only)
//   i_mode       terminate mode, latched at start
//                  00 ptr == 0, 01 signed ptr <= 0, 10 ptr == i_term,
//                  11 circular (ptr == first walked pointer)
//   i_term       explicit terminator value, latched at start
//   i_ptr        incoming pointer
//   i_ptr_valid  i_ptr valid
//   o_ptr_ready  pointer accepted this cycle (independent of i_ptr_valid)
//   o_length     node count; holds in IDLE until the next start
//   o_busy       walk in progress (SKIP, WALK, DONE)
//   o_done       one-cycle completion pulse
//   f_overrun    guard tripped; sticky until the next start
// ---------------------------------------------------------------------------
module list_length_counter #(
    parameter int unsigned WORD_SIZE = 24,
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned MAX_NODES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [1:0]           i_mode,
    input  logic [WORD_SIZE-1:0] i_term,
    input  logic [WORD_SIZE-1:0] i_ptr,
    input  logic                 i_ptr_valid,
    output logic                 o_ptr_ready,
    output logic [LEN_WIDTH-1:0] o_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 f_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_WALK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NULL = 2'b00;
    localparam logic [1:0] MODE_SIGN = 2'b01;
    localparam logic [1:0] MODE_TERM = 2'b10;
    localparam logic [1:0] MODE_CIRC = 2'b11;

`ifdef LIST_LEN_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    localparam logic [LEN_WIDTH-1:0] GUARD_LIMIT = LEN_WIDTH'(MAX_NODES);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);

    // Registered state and outputs
    state_t                 state_q,     state_d;
    logic [1:0]             mode_q,      mode_d;
    logic [WORD_SIZE-1:0]   term_q,      term_d;
    logic [WORD_SIZE-1:0]   head_q,      head_d;
    logic                   head_seen_q, head_seen_d;
    logic [LEN_WIDTH-1:0]   length_q,    length_d;
    logic                   ready_q,     ready_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   overrun_q,   overrun_d;

    logic                   beat_c;
    logic                   hit_c;
    logic                   guard_hit_c;

    // A beat is a valid pointer presented while the block advertises ready
    assign beat_c = i_ptr_valid && ready_q;

    // Terminate condition for the current pointer under the latched mode
    always_comb begin
        hit_c = 1'b0;
        case (mode_q)
            MODE_NULL: hit_c = (i_ptr == '0);
            MODE_SIGN: hit_c = i_ptr[WORD_SIZE-1] || (i_ptr == '0);
            MODE_TERM: hit_c = (i_ptr == term_q);
            // first circular beat is the head itself, never a terminator
            MODE_CIRC: hit_c = head_seen_q && (i_ptr == head_q);
            default:   hit_c = 1'b0;
        endcase
    end

    // Runaway guard: counter already at the limit and another node arrives
    assign guard_hit_c = GUARD_EN && (length_q == GUARD_LIMIT);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        term_d      = term_q;
        head_d      = head_q;
        head_seen_d = head_seen_q;
        length_d    = length_q;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_SKIP;
                    mode_d      = i_mode;
                    term_d      = i_term;
                    head_seen_d = 1'b0;
                    length_d    = '0;
                    overrun_d   = 1'b0;
                end
            end

            // The initial PC beat is consumed and dropped
            ST_SKIP: begin
                if (beat_c) begin
                    state_d = ST_WALK;
                end
            end

            ST_WALK: begin
                if (beat_c) begin
                    if (hit_c) begin
                        state_d = ST_DONE;
                    end else if (guard_hit_c) begin
                        overrun_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        length_d = length_q + LEN_ONE;
                    end
                    if ((mode_q == MODE_CIRC) && !head_seen_q) begin
                        head_d      = i_ptr;
                        head_seen_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they can be registered
        ready_d = (state_d == ST_SKIP) || (state_d == ST_WALK);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NULL;
            term_q      <= '0;
            head_q      <= '0;
            head_seen_q <= 1'b0;
            length_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            term_q      <= term_d;
            head_q      <= head_d;
            head_seen_q <= head_seen_d;
            length_q    <= length_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_ptr_ready = ready_q;
    assign o_length    = length_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign f_overrun   = overrun_q;

endmodule

// File: tb/tb_list_length_counter.sv
// ---------------------------------------------------------------------------
// Testbench for list_length_counter. Two instances are used: a wide one
// (LEN_WIDTH 16, MAX_NODES 4) and a narrow one (LEN_WIDTH 2, MAX_NODES 3),
// so that both count wrapping and the runaway guard show up in short lists.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_list_length_counter;

`ifdef LIST_LEN_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam int W0 = 16;
    localparam int M0 = 4;
    localparam int W1 = 2;
    localparam int M1 = 3;

    logic        clk;
    logic        reset;
    logic        start [2];
    logic [1:0]  mode  [2];
    logic [23:0] term  [2];
    logic [23:0] ptr   [2];
    logic        valid [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic        ovr   [2];
    logic [15:0] len0;
    logic [1:0]  len1;

    int vectors;
    int miscompares;

    list_length_counter #(.WORD_SIZE(24), .LEN_WIDTH(W0), .MAX_NODES(M0)) u_dut0 (
        .clk(clk), .reset(reset), .i_start(start[0]), .i_mode(mode[0]),
        .i_term(term[0]), .i_ptr(ptr[0]), .i_ptr_valid(valid[0]),
        .o_ptr_ready(ready[0]), .o_length(len0), .o_busy(busy[0]),
        .o_done(done[0]), .f_overrun(ovr[0])
    );

    list_length_counter #(.WORD_SIZE(24), .LEN_WIDTH(W1), .MAX_NODES(M1)) u_dut1 (
        .clk(clk), .reset(reset), .i_start(start[1]), .i_mode(mode[1]),
        .i_term(term[1]), .i_ptr(ptr[1]), .i_ptr_valid(valid[1]),
        .o_ptr_ready(ready[1]), .o_length(len1), .o_busy(busy[1]),
        .o_done(done[1]), .f_overrun(ovr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic [1:0]  m;
        logic [23:0] t;
        logic [23:0] b [8];
        int          nb;
        bit          gaps;
        int          len;
        bit          ovr;
        int          beats;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [31:0] get_len(input int d);
        return (d == 0) ? 32'(len0) : 32'(len1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk the beats (skip beat excluded) by the terminate rules
    task automatic ref_walk(input int lw, input int maxn, input logic [1:0] m,
                            input logic [23:0] t, input logic [23:0] b[$],
                            output int len, output bit ov, output int nbeats);
        bit stop;
        len = 0; ov = 1'b0; nbeats = 1;
        for (int i = 0; i < b.size(); i++) begin
            case (m)
                2'b00:   stop = (b[i] == 24'd0);
                2'b01:   stop = (b[i] == 24'd0) || b[i][23];
                2'b10:   stop = (b[i] == t);
                default: stop = (i > 0) && (b[i] == b[0]);
            endcase
            nbeats = i + 2;
            if (stop) return;
            if (GUARD && len == maxn) begin
                ov = 1'b1;
                return;
            end
            len = (len + 1) % (1 << lw);
        end
    endtask

    // One complete walk; 'all' includes the discarded initial PC beat
    task automatic do_walk(input int d, input logic [1:0] m, input logic [23:0] t,
                           input logic [23:0] all[$], input bit gaps,
                           input int exp_len, input bit exp_ovr, input int exp_beats,
                           input string tag);
        int k;
        bit got;
        start[d] = 1'b1; mode[d] = m; term[d] = t;
        @(negedge clk);
        start[d] = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy[d]), 1);
        chk({tag, " ready_after_start"}, 32'(ready[d]), 1);
        chk({tag, " len_cleared"}, get_len(d), 0);
        chk({tag, " ovr_cleared"}, 32'(ovr[d]), 0);
        k = 0; got = 1'b0;
        while (!got && k < all.size()) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    chk({tag, " stall_no_done"}, 32'(done[d]), 0);
                end
            end
            chk({tag, " ready_before_beat"}, 32'(ready[d]), 1);
            valid[d] = 1'b1; ptr[d] = all[k]; k++;
            @(negedge clk);
            valid[d] = 1'b0;
            got = done[d];
        end
        chk({tag, " done_pulse"}, 32'(got), 1);
        chk({tag, " beats_taken"}, 32'(k), 32'(exp_beats));
        chk({tag, " length"}, get_len(d), 32'(exp_len));
        chk({tag, " overrun"}, 32'(ovr[d]), 32'(exp_ovr));
        chk({tag, " ready_in_done"}, 32'(ready[d]), 0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done[d]), 0);
        chk({tag, " idle_not_busy"}, 32'(busy[d]), 0);
        chk({tag, " length_held"}, get_len(d), 32'(exp_len));
        chk({tag, " overrun_sticky"}, 32'(ovr[d]), 32'(exp_ovr));
    endtask

    initial begin
        logic [23:0] q [$];
        int el, eb;
        bit eo;

        vectors = 0; miscompares = 0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; mode[d] = 2'b00; term[d] = '0; ptr[d] = '0; valid[d] = 1'b0;
        end

        tbl[0] = '{0, 2'b00, 24'h0,      '{24'h123456, 24'h10, 24'h20, 24'h30, 24'h0, 24'h0, 24'h0, 24'h0}, 5, 1'b0, 3, 1'b0, 5};
        tbl[1] = '{0, 2'b01, 24'h0,      '{24'h000111, 24'h05, 24'h07, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0}, 4, 1'b0, 2, 1'b0, 4};
        tbl[2] = '{0, 2'b01, 24'h0,      '{24'h000111, 24'h05, 24'h07, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0}, 4, 1'b1, 2, 1'b0, 4};
        tbl[3] = '{0, 2'b10, 24'hABCDEF, '{24'h000222, 24'h01, 24'h02, 24'hABCDEF, 24'h0, 24'h0, 24'h0, 24'h0}, 4, 1'b0, 2, 1'b0, 4};
        tbl[4] = '{0, 2'b11, 24'h0,      '{24'h000333, 24'h40, 24'h50, 24'h60, 24'h40, 24'h0, 24'h0, 24'h0}, 5, 1'b1, 3, 1'b0, 5};
        tbl[5] = '{0, 2'b00, 24'h0,      '{24'h000444, 24'h01, 24'h02, 24'h03, 24'h04, 24'h05, 24'h06, 24'h0}, 8, 1'b0,
                   GUARD ? 4 : 6, GUARD, GUARD ? 6 : 8};
        tbl[6] = '{1, 2'b00, 24'h0,      '{24'h000555, 24'h01, 24'h02, 24'h03, 24'h04, 24'h05, 24'h0, 24'h0}, 7, 1'b1,
                   GUARD ? 3 : 1, GUARD, GUARD ? 5 : 7};
        tbl[7] = '{0, 2'b00, 24'h0,      '{24'h000666, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}, 2, 1'b0, 0, 1'b0, 2};
        tbl[8] = '{0, 2'b11, 24'h0,      '{24'h000777, 24'h0, 24'h05, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}, 4, 1'b0, 2, 1'b0, 4};
        tbl[9] = '{1, 2'b01, 24'h0,      '{24'h000888, 24'h800000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0}, 2, 1'b1, 0, 1'b0, 2};

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_len%0d", d), get_len(d), 0);
            chk($sformatf("reset_busy%0d", d), 32'(busy[d]), 0);
            chk($sformatf("reset_done%0d", d), 32'(done[d]), 0);
            chk($sformatf("reset_ready%0d", d), 32'(ready[d]), 0);
            chk($sformatf("reset_ovr%0d", d), 32'(ovr[d]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            q.delete();
            for (int j = 0; j < tbl[i].nb; j++) q.push_back(tbl[i].b[j]);
            do_walk(tbl[i].d, tbl[i].m, tbl[i].t, q, tbl[i].gaps,
                    tbl[i].len, tbl[i].ovr, tbl[i].beats, $sformatf("vec%0d", i));
        end

        // Reset mid-walk after two counted beats aborts without o_done
        start[0] = 1'b1; mode[0] = 2'b00;
        @(negedge clk);
        start[0] = 1'b0;
        valid[0] = 1'b1; ptr[0] = 24'h5;  @(negedge clk);
        ptr[0] = 24'h10; @(negedge clk);
        ptr[0] = 24'h20; @(negedge clk);
        valid[0] = 1'b0;
        chk("abort_len_before", get_len(0), 2);
        chk("abort_busy_before", 32'(busy[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_len", get_len(0), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_ready", 32'(ready[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done_later", 32'(done[0]), 0);
        end

        // i_start while busy is ignored, including a changed mode/term
        start[0] = 1'b1; mode[0] = 2'b00; term[0] = 24'h0;
        @(negedge clk);
        start[0] = 1'b0;
        valid[0] = 1'b1; ptr[0] = 24'h5;
        @(negedge clk);
        start[0] = 1'b1; mode[0] = 2'b10; term[0] = 24'h10; ptr[0] = 24'h10;
        @(negedge clk);
        start[0] = 1'b0; mode[0] = 2'b00;
        chk("busy_start_no_done", 32'(done[0]), 0);
        chk("busy_start_len1", get_len(0), 1);
        ptr[0] = 24'h20;
        @(negedge clk);
        chk("busy_start_len2", get_len(0), 2);
        ptr[0] = 24'h0;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("busy_start_done", 32'(done[0]), 1);
        chk("busy_start_final_len", get_len(0), 2);
        @(negedge clk);
        chk("busy_start_idle", 32'(busy[0]), 0);

        // Randomized walks against the reference
        for (int it = 0; it < 40; it++) begin
            int d, n;
            logic [1:0] m;
            logic [23:0] t;
            logic [23:0] w [$];
            d = it % 2;
            m = 2'($urandom_range(0, 3));
            t = 24'($urandom);
            n = $urandom_range(1, 7);
            w.delete();
            for (int i = 0; i < n; i++) begin
                int r = $urandom_range(0, 7);
                case (r)
                    0:       w.push_back(24'h0);
                    1:       w.push_back(t);
                    2:       w.push_back(24'h800000 | 24'($urandom));
                    3:       w.push_back((i > 0) ? w[0] : 24'h1234);
                    default: w.push_back((24'($urandom) & 24'h7FFFFF) | 24'h1);
                endcase
            end
            w.push_back((m == 2'b11) ? w[0] : ((m == 2'b10) ? t : 24'h0));
            ref_walk((d == 0) ? W0 : W1, (d == 0) ? M0 : M1, m, t, w, el, eo, eb);
            q = w;
            q.push_front(24'($urandom));
            do_walk(d, m, t, q, bit'($urandom_range(0, 1)), el, eo, eb, $sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
